// File: rtl/tlc_phase_fsm_if.sv
// rtl/tlc_phase_fsm_if.sv - handshake between the phase sequencer and the shared phase timer
//   timer_en   : sequencer -> timer, count enable
//   t_max      : sequencer -> timer, terminal count (phase length - 1)
//   timer_done : timer -> sequencer, count has reached t_max
interface tlc_phase_fsm_if #(
    parameter int N = 6
);
    logic         timer_en;
    logic [N-1:0] t_max;
    logic         timer_done;

    modport master (
        output timer_en,
        output t_max,
        input  timer_done
    );

    modport slave (
        input  timer_en,
        input  t_max,
        output timer_done
    );
endinterface

// File: rtl/tlc_phase_fsm.sv
// rtl/tlc_phase_fsm.sv - phase sequencer for the two-road traffic light with pedestrian walk
//   clk        : clock
//   res        : synchronous active-high reset
//   car_side   : side-road vehicle sensor (level)
//   ped_req    : pedestrian button (pulse or level)
//   flash      : flash/night mode request (level)
//   tmr        : timer handshake (timer_en, t_max out; timer_done in)
//   main_light : main road lamps {R,Y,G}
//   side_light : side road lamps {R,Y,G}
//   walk       : walk lamp
//   state      : current phase code
module tlc_phase_fsm #(
    parameter int N       = 6,
    parameter int T_MG    = 30,
    parameter int T_Y     = 4,
    parameter int T_AR    = 2,
    parameter int T_SG    = 20,
    parameter int T_WALK  = 15,
    parameter int T_FLASH = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             car_side,
    input  logic             ped_req,
    input  logic             flash,
    tlc_phase_fsm_if.master  tmr,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        AR_A  = 3'd2,
        SG    = 3'd3,
        SY    = 3'd4,
        AR_B  = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } phase_t;

    // Terminal counts are one less than the phase length, truncated to the timer width.
    localparam logic [N-1:0] TM_MG    = N'(T_MG - 1);
    localparam logic [N-1:0] TM_Y     = N'(T_Y - 1);
    localparam logic [N-1:0] TM_AR    = N'(T_AR - 1);
    localparam logic [N-1:0] TM_SG    = N'(T_SG - 1);
    localparam logic [N-1:0] TM_WALK  = N'(T_WALK - 1);
    localparam logic [N-1:0] TM_FLASH = N'(T_FLASH - 1);

    phase_t cur;
    phase_t nxt;
    logic   blink;
    logic   blink_nxt;
    logic   car_pend;
    logic   car_nxt;
    logic   ped_pend;
    logic   ped_nxt;
    logic   advance;

    function automatic logic [N-1:0] tmax_of(input phase_t p);
        case (p)
            MG:        return TM_MG;
            MY, SY:    return TM_Y;
            AR_A, AR_B: return TM_AR;
            SG:        return TM_SG;
            WALK:      return TM_WALK;
            default:   return TM_FLASH;
        endcase
    endfunction

    function automatic logic [2:0] main_of(input phase_t p, input logic b);
        case (p)
            MG:      return 3'b001;
            MY:      return 3'b010;
            FLASH:   return b ? 3'b010 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] side_of(input phase_t p, input logic b);
        case (p)
            SG:      return 3'b001;
            SY:      return 3'b010;
            FLASH:   return b ? 3'b100 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    assign tmr.timer_en = ~res;
    assign advance      = tmr.timer_done & tmr.timer_en;
    assign state        = cur;

    always_comb begin
        nxt       = cur;
        blink_nxt = blink;
        if (advance) begin
            if (flash && cur != FLASH) begin
                nxt       = FLASH;
                blink_nxt = 1'b1;
            end else begin
                case (cur)
                    FLASH: begin
                        if (flash) blink_nxt = ~blink;
                        else       nxt       = AR_B;
                    end
                    MG:      nxt = (car_pend || ped_pend) ? MY : MG;
                    MY:      nxt = AR_A;
                    AR_A:    nxt = car_pend ? SG : WALK;
                    SG:      nxt = SY;
                    SY:      nxt = AR_B;
                    AR_B:    nxt = ped_pend ? WALK : MG;
                    WALK:    nxt = MG;
                    default: nxt = MG;
                endcase
            end
        end

        // Requests are served by the phase they ask for; clearing on entry wins over a
        // coincident new request.
        if (nxt == SG && cur != SG) car_nxt = 1'b0;
        else                        car_nxt = car_pend | (car_side & (cur != SG));

        if (nxt == WALK && cur != WALK) ped_nxt = 1'b0;
        else                            ped_nxt = ped_pend | (ped_req & (cur != WALK));
    end

    // Lamp and terminal-count registers are loaded from the next phase so they change on
    // the same edge as the phase itself.
    always_ff @(posedge clk) begin
        if (res) begin
            cur        <= MG;
            blink      <= 1'b1;
            car_pend   <= 1'b0;
            ped_pend   <= 1'b0;
            main_light <= 3'b001;
            side_light <= 3'b100;
            walk       <= 1'b0;
            tmr.t_max  <= TM_MG;
        end else begin
            cur        <= nxt;
            blink      <= blink_nxt;
            car_pend   <= car_nxt;
            ped_pend   <= ped_nxt;
            main_light <= main_of(nxt, blink_nxt);
            side_light <= side_of(nxt, blink_nxt);
            walk       <= (nxt == WALK);
            tmr.t_max  <= tmax_of(nxt);
        end
    end

endmodule
